// File: rtl/thread_sched_pkg.sv
// Shared definitions for the two-thread barrel scheduler: widths, thread
// states and the opcode constants that decode uses to flag control flow.
package thread_sched_pkg;

   localparam int WORD_W      = 16;
   localparam int OPCODE_W    = 4;
   localparam int TID_W       = 1;
   localparam int NUM_THREADS = 2;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [OPCODE_W-1:0] opcode_t;
   typedef logic [TID_W-1:0]    tid_t;

   // Per-thread execution state.
   typedef enum logic [1:0] {
      TS_RUN    = 2'b00,
      TS_WAIT   = 2'b01,
      TS_HALTED = 2'b10
   } thread_state_e;

   // Opcode map seen by decode. Control-flow opcodes park the issuing
   // thread in WAIT until the outcome is resolved.
   localparam opcode_t OP_NOP   = 4'h0;
   localparam opcode_t OP_ADD   = 4'h1;
   localparam opcode_t OP_SUB   = 4'h2;
   localparam opcode_t OP_AND   = 4'h3;
   localparam opcode_t OP_OR    = 4'h4;
   localparam opcode_t OP_XOR   = 4'h5;
   localparam opcode_t OP_LOAD  = 4'h6;
   localparam opcode_t OP_STORE = 4'h7;
   localparam opcode_t OP_JUMP  = 4'h8;
   localparam opcode_t OP_JUMPF = 4'h9;
   localparam opcode_t OP_JUMPT = 4'hA;
   localparam opcode_t OP_CALL  = 4'hB;
   localparam opcode_t OP_RET   = 4'hC;
   localparam opcode_t OP_SYS   = 4'hF;

   // True for opcodes after which decode must raise block_valid.
   function automatic logic is_ctrl_flow(input opcode_t op);
      return (op == OP_JUMP) || (op == OP_JUMPF) || (op == OP_JUMPT) ||
             (op == OP_CALL) || (op == OP_RET);
   endfunction

endpackage

// File: rtl/thread_sched_ctx.sv
// One thread's architectural context: program counter, run state, and the
// priority ordering of sys / resolve / block events aimed at this thread.
module thread_ctx
   import thread_sched_pkg::*;
#(
   parameter word_t PC_INIT = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          issue_en,
   input  logic          block,
   input  logic          resolve,
   input  logic          resolve_taken,
   input  word_t         resolve_pc,
   input  logic          sys,
   output word_t         pc,
   output thread_state_e state,
   output thread_state_e state_next
);

   word_t         pc_q, pc_d;
   thread_state_e state_q, state_d;

   // Next-state: sys beats resolve beats block; the highest-priority event
   // present is the only one considered, even if it is then ignored.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      // Issue was decided on the pre-edge state, so the increment happens
      // first and a taken resolve below may overwrite it.
      if (issue_en) begin
         pc_d = pc_q + word_t'(1);
      end
      if (sys) begin
         state_d = TS_HALTED;
      end else if (resolve) begin
         if (state_q == TS_WAIT) begin
            state_d = TS_RUN;
            if (resolve_taken) begin
               pc_d = resolve_pc;
            end
         end
      end else if (block) begin
         if (state_q == TS_RUN) begin
            state_d = TS_WAIT;
         end
      end
   end

   // Context registers; reset restores the init PC and RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= PC_INIT;
         state_q <= TS_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign pc         = pc_q;
   assign state      = state_q;
   assign state_next = state_d;

endmodule

// File: rtl/thread_sched.sv
// Two-thread fine-grained barrel scheduler. A slot bit alternates between
// threads every unstalled cycle; a thread that is not RUN leaves a bubble
// in its slot rather than lending it to the other thread.
module thread_sched
   import thread_sched_pkg::*;
#(
   parameter logic [15:0] PC0_INIT = 16'h0000,
   parameter logic [15:0] PC1_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        block_valid,
   input  logic        block_tid,
   input  logic        resolve_valid,
   input  logic        resolve_tid,
   input  logic        resolve_taken,
   input  logic [15:0] resolve_pc,
   input  logic        sys_valid,
   input  logic        sys_tid,
   output logic        issue_valid,
   output logic        issue_tid,
   output logic [15:0] issue_pc,
   output logic        halt
);

   word_t         thr_pc         [NUM_THREADS];
   thread_state_e thr_state      [NUM_THREADS];
   thread_state_e thr_state_next [NUM_THREADS];
   logic [NUM_THREADS-1:0] issue_en;

   tid_t  slot_q, slot_d;
   logic  issue_valid_q, issue_valid_d;
   tid_t  issue_tid_q, issue_tid_d;
   word_t issue_pc_q, issue_pc_d;
   logic  halt_q, halt_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
         // A thread issues only when it owns the slot, the pipe accepts,
         // and its registered state is RUN.
         assign issue_en[gi] = !stall && (slot_q == tid_t'(gi)) &&
                               (thr_state[gi] == TS_RUN);

         thread_ctx #(
            .PC_INIT (gi == 0 ? PC0_INIT : PC1_INIT)
         ) u_ctx (
            .clk           (clk),
            .reset         (reset),
            .issue_en      (issue_en[gi]),
            .block         (block_valid && (block_tid == tid_t'(gi))),
            .resolve       (resolve_valid && (resolve_tid == tid_t'(gi))),
            .resolve_taken (resolve_taken),
            .resolve_pc    (resolve_pc),
            .sys           (sys_valid && (sys_tid == tid_t'(gi))),
            .pc            (thr_pc[gi]),
            .state         (thr_state[gi]),
            .state_next    (thr_state_next[gi])
         );
      end
   endgenerate

   // Slot rotation and issue selection; outputs hold tid/pc on bubbles.
   always_comb begin
      slot_d        = stall ? slot_q : ~slot_q;
      issue_valid_d = |issue_en;
      issue_tid_d   = issue_tid_q;
      issue_pc_d    = issue_pc_q;
      if (issue_valid_d) begin
         issue_tid_d = slot_q;
         issue_pc_d  = thr_pc[slot_q];
      end
      // Halt reflects the post-update state so it rises on the same edge
      // as the second sys.
      halt_d = (thr_state_next[0] == TS_HALTED) &&
               (thr_state_next[1] == TS_HALTED);
   end

   // Slot and registered issue/halt outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q        <= '0;
         issue_valid_q <= 1'b0;
         issue_tid_q   <= '0;
         issue_pc_q    <= '0;
         halt_q        <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         issue_valid_q <= issue_valid_d;
         issue_tid_q   <= issue_tid_d;
         issue_pc_q    <= issue_pc_d;
         halt_q        <= halt_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_tid   = issue_tid_q;
   assign issue_pc    = issue_pc_q;
   assign halt        = halt_q;

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: per-scenario stimulus tables with
// hand-derived expected issue streams.
module tb_thread_sched;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        block_valid;
   logic        block_tid;
   logic        resolve_valid;
   logic        resolve_tid;
   logic        resolve_taken;
   logic [15:0] resolve_pc;
   logic        sys_valid;
   logic        sys_tid;

   logic        issue_valid,  issue_valid2;
   logic        issue_tid,    issue_tid2;
   logic [15:0] issue_pc,     issue_pc2;
   logic        halt,         halt2;

   int checks   = 0;
   int failures = 0;

   thread_sched dut (
      .clk(clk), .reset(reset), .stall(stall),
      .block_valid(block_valid), .block_tid(block_tid),
      .resolve_valid(resolve_valid), .resolve_tid(resolve_tid),
      .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
      .sys_valid(sys_valid), .sys_tid(sys_tid),
      .issue_valid(issue_valid), .issue_tid(issue_tid),
      .issue_pc(issue_pc), .halt(halt)
   );

   thread_sched #(.PC0_INIT(16'hFFFF), .PC1_INIT(16'h1234)) dut2 (
      .clk(clk), .reset(reset), .stall(stall),
      .block_valid(block_valid), .block_tid(block_tid),
      .resolve_valid(resolve_valid), .resolve_tid(resolve_tid),
      .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
      .sys_valid(sys_valid), .sys_tid(sys_tid),
      .issue_valid(issue_valid2), .issue_tid(issue_tid2),
      .issue_pc(issue_pc2), .halt(halt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        blk;
      logic        btid;
      logic        res;
      logic        rtid;
      logic        rtk;
      logic [15:0] rpc;
      logic        sys;
      logic        stid;
   } stim_t;

   function automatic stim_t st_idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t st_stall();
      stim_t s;
      s = '0;
      s.stall = 1'b1;
      return s;
   endfunction

   function automatic stim_t st_block(input logic tid);
      stim_t s;
      s = '0;
      s.blk  = 1'b1;
      s.btid = tid;
      return s;
   endfunction

   function automatic stim_t st_res(input logic tid, input logic tk, input logic [15:0] pc);
      stim_t s;
      s = '0;
      s.res  = 1'b1;
      s.rtid = tid;
      s.rtk  = tk;
      s.rpc  = pc;
      return s;
   endfunction

   function automatic stim_t st_sys(input logic tid);
      stim_t s;
      s = '0;
      s.sys  = 1'b1;
      s.stid = tid;
      return s;
   endfunction

   // Expected word {halt, valid, tid, pc}; bubbles carry zero tid/pc.
   function automatic logic [18:0] E(input logic t, input logic [15:0] pc);
      return {1'b0, 1'b1, t, pc};
   endfunction

   function automatic logic [18:0] B(input logic h);
      return {h, 18'b0};
   endfunction

   task automatic drive(input stim_t v);
      stall         = v.stall;
      block_valid   = v.blk;
      block_tid     = v.btid;
      resolve_valid = v.res;
      resolve_tid   = v.rtid;
      resolve_taken = v.rtk;
      resolve_pc    = v.rpc;
      sys_valid     = v.sys;
      sys_tid       = v.stid;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(st_idle());
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [18:0] obs1();
      logic [18:0] o;
      o = {halt, issue_valid, issue_tid, issue_pc};
      if (!issue_valid) o[16:0] = '0;
      return o;
   endfunction

   function automatic logic [18:0] obs2();
      logic [18:0] o;
      o = {halt2, issue_valid2, issue_tid2, issue_pc2};
      if (!issue_valid2) o[16:0] = '0;
      return o;
   endfunction

   task automatic test_reset();
      logic [18:0] o;
      drive(st_idle());
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      // Asynchronous assertion mid-cycle must clear outputs without an edge.
      #2;
      reset = 1'b1;
      #1;
      o = {halt, issue_valid, issue_tid, issue_pc};
      checks++;
      if (o !== 19'b0) begin
         failures++;
         $display("FAIL reset_async actual=%h required=%h", o, 19'b0);
      end
      tick();
      o = {halt, issue_valid, issue_tid, issue_pc};
      checks++;
      if (o !== 19'b0) begin
         failures++;
         $display("FAIL reset_held actual=%h required=%h", o, 19'b0);
      end
      o = {halt2, issue_valid2, issue_tid2, issue_pc2};
      checks++;
      if (o !== 19'b0) begin
         failures++;
         $display("FAIL reset_dut2 actual=%h required=%h", o, 19'b0);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      stim_t       sv[4];
      logic [18:0] ev[4];
      for (int i = 0; i < 4; i++) sv[i] = st_idle();
      ev[0] = E(0, 16'h0000); ev[1] = E(1, 16'h0000);
      ev[2] = E(0, 16'h0001); ev[3] = E(1, 16'h0001);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL basic[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   task automatic test_block_resolve();
      stim_t       sv[7];
      logic [18:0] ev[7];
      sv[0] = st_idle();                   ev[0] = E(0, 16'h0000);
      sv[1] = st_block(0);                 ev[1] = E(1, 16'h0000);
      sv[2] = st_idle();                   ev[2] = B(0);
      sv[3] = st_res(0, 1'b1, 16'h0040);   ev[3] = E(1, 16'h0001);
      sv[4] = st_idle();                   ev[4] = E(0, 16'h0040);
      sv[5] = st_idle();                   ev[5] = E(1, 16'h0002);
      sv[6] = st_idle();                   ev[6] = E(0, 16'h0041);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL block_resolve[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Block raised on the very edge t0 issues, then a not-taken resolve.
      stim_t       sv[5];
      logic [18:0] ev[5];
      sv[0] = st_block(0);                 ev[0] = E(0, 16'h0000);
      sv[1] = st_idle();                   ev[1] = E(1, 16'h0000);
      sv[2] = st_res(0, 1'b0, 16'hBEEF);   ev[2] = B(0);
      sv[3] = st_idle();                   ev[3] = E(1, 16'h0001);
      sv[4] = st_idle();                   ev[4] = E(0, 16'h0001);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL back_to_back[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   task automatic test_stall();
      stim_t       sv[7];
      logic [18:0] ev[7];
      sv[0] = st_idle();  ev[0] = E(0, 16'h0000);
      sv[1] = st_idle();  ev[1] = E(1, 16'h0000);
      sv[2] = st_stall(); ev[2] = B(0);
      sv[3] = st_stall(); ev[3] = B(0);
      sv[4] = st_stall(); ev[4] = B(0);
      sv[5] = st_idle();  ev[5] = E(0, 16'h0001);
      sv[6] = st_idle();  ev[6] = E(1, 16'h0001);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL stall[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   task automatic test_sys();
      stim_t       sv[8];
      logic [18:0] ev[8];
      sv[0] = st_idle();   ev[0] = E(0, 16'h0000);
      sv[1] = st_sys(1);   ev[1] = E(1, 16'h0000);
      sv[2] = st_idle();   ev[2] = E(0, 16'h0001);
      sv[3] = st_idle();   ev[3] = B(0);
      sv[4] = st_idle();   ev[4] = E(0, 16'h0002);
      sv[5] = st_sys(0);   ev[5] = B(1);
      sv[6] = st_idle();   ev[6] = B(1);
      sv[7] = st_idle();   ev[7] = B(1);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL sys[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [18:0] ev[4];
      ev[0] = E(0, 16'hFFFF); ev[1] = E(1, 16'h1234);
      ev[2] = E(0, 16'h0000); ev[3] = E(1, 16'h1235);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(st_idle());
         tick();
         checks++;
         if (obs2() !== ev[i]) begin
            failures++;
            $display("FAIL wrap[%0d] actual=%h required=%h", i, obs2(), ev[i]);
         end
      end
   endtask

   task automatic test_sys_resolve_reset();
      stim_t       sv[6];
      logic [18:0] ev[6];
      logic [18:0] o;
      sv[0] = st_idle();                   ev[0] = E(0, 16'h0000);
      sv[1] = st_block(0);                 ev[1] = E(1, 16'h0000);
      sv[2] = st_res(0, 1'b1, 16'h0080);
      sv[2].sys  = 1'b1;
      sv[2].stid = 1'b0;                   ev[2] = B(0);
      sv[3] = st_idle();                   ev[3] = E(1, 16'h0001);
      sv[4] = st_idle();                   ev[4] = B(0);
      sv[5] = st_idle();                   ev[5] = E(1, 16'h0002);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(sv[i]);
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL sys_resolve[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
      // Mid-run reset with an event pending on the inputs.
      drive(st_block(0));
      #2;
      reset = 1'b1;
      #1;
      o = obs1();
      checks++;
      if (o !== B(0)) begin
         failures++;
         $display("FAIL midrun_reset actual=%h required=%h", o, B(0));
      end
      tick();
      drive(st_idle());
      reset = 1'b0;
      ev[0] = E(0, 16'h0000); ev[1] = E(1, 16'h0000); ev[2] = E(0, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs1() !== ev[i]) begin
            failures++;
            $display("FAIL after_reset[%0d] actual=%h required=%h", i, obs1(), ev[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(st_idle());
      test_reset();
      test_basic();
      test_block_resolve();
      test_back_to_back();
      test_stall();
      test_sys();
      test_wrap();
      test_sys_resolve_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
